sub_rr_arbiter: RTL and testbench
=================================

// Module: sub_rr_arbiter
// PURPOSE
//  Shares one 32-bit subtract datapath (diff = a - b, signed overflow flag) among
//  NUM_REQ requesters using round-robin arbitration.
//  Sits between the requesting engines and downstream consumers.
//  Accepts at most one operation per cycle and returns the registered result,
//  tagged with the requester ID, over a valid/ready response channel.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..16)
//  WIDTH    32  operand/result width
//  ID_W     2   requester ID width; must equal $clog2(NUM_REQ)
//  CNT_W    16  width of accepted-operation counter
// PORTS
//  clk           in   1              clock, rising edge
//  rst           in   1              reset, asynchronous, active-high
//  req_valid     in   NUM_REQ        per-requester operation request
//  req_ready     out  NUM_REQ        per-requester grant/accept (one-hot or zero)
//  req_a         in   NUM_REQ*WIDTH  minuends, requester i at [i*WIDTH +: WIDTH]
//  req_b         in   NUM_REQ*WIDTH  subtrahends, same packing
//  rsp_valid     out  1              result register holds a valid result
//  rsp_ready     in   1              downstream accepts result
//  rsp_id        out  ID_W           requester index that issued the result
//  rsp_diff      out  WIDTH          a - b, modulo 2^WIDTH
//  rsp_overflow  out  1              signed overflow of a - b
//  rsp_borrow    out  1              unsigned borrow (a < b unsigned)
//  op_count      out  CNT_W          number of accepted operations, wraps
//  busy          out  1              rsp_valid | (|req_valid)
// BEHAVIOUR
//  Reset (async on rst high):
//   - rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_overflow=0, rsp_borrow=0.
//   - op_count=0; RR pointer=0, so requester 0 has top priority.
//  Output register states:
//   - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
//   - slot_free = !rsp_valid | rsp_ready.
//  Arbitration (combinational):
//   - When slot_free, grant the first i with req_valid[i], searching ptr, ptr+1, ...
//     with wrap at NUM_REQ-1 -> 0.
//   - req_ready = grant (one-hot); all zeros when !slot_free or no request.
//  Accept = |(req_valid & req_ready). On an accept edge:
//   - Register rsp_diff, rsp_overflow, rsp_borrow and rsp_id from the granted
//     operands; set rsp_valid=1.
//   - ptr <= granted index + 1, modulo NUM_REQ.
//   - op_count <= op_count + 1, wrapping at 2^CNT_W.
//  Edge with rsp_valid & rsp_ready and no accept: rsp_valid <= 0. Data regs hold.
//  Simultaneous drain and accept: the new result replaces the old one and rsp_valid
//   stays 1. This gives full throughput of 1 op/cycle.
//  FULL with !rsp_ready: result regs frozen; no grant; ptr and op_count hold.
//  Latency: accept at edge N -> rsp_valid visible after edge N (1 cycle).
//  Arithmetic on granted operands a, b:
//   - diff = a - b, truncated to WIDTH.
//   - overflow = (a[W-1]^b[W-1]) & (diff[W-1]^a[W-1]).
//   - borrow = carry-out of the WIDTH+1-bit unsigned a - b.
//  Requester rules:
//   - Hold req_valid, req_a and req_b stable until req_ready is seen.
//   - req_ready may depend combinationally on req_valid and rsp_ready.
//   - rsp_ready must not depend on req_ready.
//  Reset asserted mid-operation: pending result is discarded, and ptr and op_count
//   clear. No response is issued for an op accepted in the cycle reset asserts.
// TESTING
//  1. Single req0: a=10, b=3 -> after 1 clk: rsp_valid=1, rsp_id=0,
//     diff=7, ovf=0, borrow=0, op_count=1.
//  2. Overflow/borrow: a=32'h8000_0000, b=1 -> diff=32'h7FFF_FFFF, ovf=1, borrow=0.
//     a=0, b=1 -> diff=32'hFFFF_FFFF, ovf=0, borrow=1.
//  3. All 4 requesters valid, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles,
//     one result/cycle, op_count increments each cycle.
//  4. Backpressure: rsp_ready=0 while FULL -> req_ready=0 and result held stable
//     for 5 cycles; raise rsp_ready -> drain plus next grant in the same edge.
//  5. op_count preset to 16'hFFFF via 65535 ops -> next accept gives op_count=0.
//  6. Assert rst while FULL with req1,req2 pending -> rsp_valid=0 immediately.
//     After release: grant order starts at 1 (ptr=0, req0 idle), then 2.

Source files
------------

// File: rtl/sub_rr_arbiter_if.sv
// sub_rr_arbiter_if: request/response handshake bundle for the shared subtractor.
interface sub_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_diff;
    logic                     rsp_overflow;
    logic                     rsp_borrow;
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_overflow, rsp_borrow
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_overflow, rsp_borrow
    );
endinterface

// File: rtl/sub_rr_arbiter.sv
// sub_rr_arbiter: round-robin shared subtractor with a registered, ID-tagged result slot.
module sub_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    sub_rr_arbiter_if.slave  bus,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  gidx;
    logic [ID_W-1:0]  idx;
    logic             found;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    assign slot_free = !bus.rsp_valid || bus.rsp_ready;

    // first valid requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        gidx = '0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gidx = idx;
            end
        end
    end

    assign accept        = found && slot_free;
    assign bus.req_ready = accept ? NUM_REQ'(1) << gidx : '0;
    assign a             = bus.req_a[int'(gidx)*WIDTH +: WIDTH];
    assign b             = bus.req_b[int'(gidx)*WIDTH +: WIDTH];
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};
    assign overflow      = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    assign busy          = bus.rsp_valid | (|bus.req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id <= '0;
            bus.rsp_diff <= '0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_borrow <= 1'b0;
            op_count <= '0;
            ptr <= '0;
        end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id <= gidx;
            bus.rsp_diff <= diff;
            bus.rsp_overflow <= overflow;
            bus.rsp_borrow <= borrow;
            op_count <= op_count + 1'b1;
            ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sub_rr_arbiter.sv
// tb_sub_rr_arbiter: scoreboard bench; a negedge monitor models grants and results.
module tb_sub_rr_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_diff;
    logic        rsp_overflow;
    logic        rsp_borrow;
    logic [15:0] op_count;
    logic        busy;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] diff;
        logic        ovf;
        logic        brw;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    exp_t        hold;
    int          checks = 0;
    int          errors = 0;
    int          m_ptr = 0;
    int          m_last = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt = '0;

    sub_rr_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .ID_W(2)) bus ();

    assign bus.req_valid = req_valid;
    assign bus.req_a     = req_a;
    assign bus.req_b     = req_b;
    assign bus.rsp_ready = rsp_ready;
    assign req_ready     = bus.req_ready;
    assign rsp_valid     = bus.rsp_valid;
    assign rsp_id        = bus.rsp_id;
    assign rsp_diff      = bus.rsp_diff;
    assign rsp_overflow  = bus.rsp_overflow;
    assign rsp_borrow    = bus.rsp_borrow;

    sub_rr_arbiter #(.NUM_REQ(4), .WIDTH(32), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .op_count(op_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model and scoreboard, evaluated between edges
    always @(negedge clk) begin : monitor
        int gi;
        int j;
        logic [3:0] m_gnt;
        logic [31:0] oa;
        logic [31:0] ob;
        logic signed [32:0] sd;
        if (rst) begin
            q.delete();
            m_ptr = 0;
            m_valid = 1'b0;
            m_cnt = '0;
        end else begin
            gi = -1;
            m_gnt = '0;
            if (!m_valid || rsp_ready)
                for (int k = 0; k < 4; k++) begin
                    j = (m_ptr + k) % 4;
                    if (gi < 0 && req_valid[j]) gi = j;
                end
            if (gi >= 0) m_gnt[gi] = 1'b1;
            checks++;
            if (req_ready !== m_gnt) begin
                errors++;
                $display("FAIL grant: req_ready=%b expected %b", req_ready, m_gnt);
            end
            checks++;
            if (rsp_valid !== m_valid) begin
                errors++;
                $display("FAIL rsp_valid: got %b expected %b", rsp_valid, m_valid);
            end
            checks++;
            if (op_count !== m_cnt) begin
                errors++;
                $display("FAIL op_count: got %h expected %h", op_count, m_cnt);
            end
            checks++;
            if (busy !== (m_valid | (|req_valid))) begin
                errors++;
                $display("FAIL busy: got %b expected %b", busy, m_valid | (|req_valid));
            end
            if (m_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: result present with empty queue");
                end else if ({rsp_id, rsp_diff, rsp_overflow, rsp_borrow} !== {q[0].id, q[0].diff, q[0].ovf, q[0].brw}) begin
                    errors++;
                    $display("FAIL result: id=%0d diff=%h ovf=%b brw=%b expected id=%0d diff=%h ovf=%b brw=%b",
                             rsp_id, rsp_diff, rsp_overflow, rsp_borrow, q[0].id, q[0].diff, q[0].ovf, q[0].brw);
                end
                if (rsp_ready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    m_valid = 1'b0;
                end
            end
            if (gi >= 0) begin
                oa = req_a[gi*32 +: 32];
                ob = req_b[gi*32 +: 32];
                sd = $signed({oa[31], oa}) - $signed({ob[31], ob});
                e.id = 2'(gi);
                e.diff = oa - ob;
                e.ovf = (sd > 33'sd2147483647) || (sd < -33'sd2147483648);
                e.brw = oa < ob;
                q.push_back(e);
                m_valid = 1'b1;
                m_ptr = (gi + 1) % 4;
                m_cnt = m_cnt + 16'd1;
                m_last = gi;
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // starts and ends one time unit after a rising edge
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready[i];
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL issue_timeout: req%0d never granted", i);
        end
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_diff, rsp_overflow, rsp_borrow} !== 36'd0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b id=%0d diff=%h ovf=%b brw=%b expected all zero",
                     rsp_valid, rsp_id, rsp_diff, rsp_overflow, rsp_borrow);
        end
        checks++;
        if (op_count !== 16'd0 || req_ready !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: op_count=%h req_ready=%b expected 0 and 0", op_count, req_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        issue(0, 32'd10, 32'd3);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_diff, rsp_overflow, rsp_borrow} !== {1'b1, 2'd0, 32'd7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single: valid=%b id=%0d diff=%h ovf=%b brw=%b expected 1 0 7 0 0",
                     rsp_valid, rsp_id, rsp_diff, rsp_overflow, rsp_borrow);
        end
        checks++;
        if (op_count !== 16'd1) begin
            errors++;
            $display("FAIL single_cnt: op_count=%h expected 1", op_count);
        end
    endtask

    task automatic test_overflow();
        issue(0, 32'h8000_0000, 32'd1);
        @(negedge clk);
        checks++;
        if ({rsp_diff, rsp_overflow, rsp_borrow} !== {32'h7FFF_FFFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ovf: diff=%h ovf=%b brw=%b expected 7fffffff 1 0", rsp_diff, rsp_overflow, rsp_borrow);
        end
        issue(2, 32'd0, 32'd1);
        @(negedge clk);
        checks++;
        if ({rsp_id, rsp_diff, rsp_overflow, rsp_borrow} !== {2'd2, 32'hFFFF_FFFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL borrow: id=%0d diff=%h ovf=%b brw=%b expected 2 ffffffff 0 1",
                     rsp_id, rsp_diff, rsp_overflow, rsp_borrow);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(100 * (i + 1));
            req_b[i*32 +: 32] = 32'(7 * i + 1);
        end
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== (4'b0001 << (k % 4)) || op_count !== 16'(k)) begin
                errors++;
                $display("FAIL rr_step%0d: req_ready=%b op_count=%0d expected %b %0d",
                         k, req_ready, op_count, 4'b0001 << (k % 4), k);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int exp_id;
        rsp_ready = 1'b0;
        hold = q[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'd0 || rsp_valid !== 1'b1 || rsp_diff !== hold.diff || rsp_id !== hold.id) begin
                errors++;
                $display("FAIL hold%0d: req_ready=%b valid=%b id=%0d diff=%h expected 0000 1 %0d %h",
                         k, req_ready, rsp_valid, rsp_id, rsp_diff, hold.id, hold.diff);
            end
        end
        @(posedge clk);
        #1;
        exp_id = m_ptr;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== (4'b0001 << exp_id)) begin
            errors++;
            $display("FAIL release_grant: req_ready=%b expected %b", req_ready, 4'b0001 << exp_id);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id)) begin
            errors++;
            $display("FAIL release_rsp: valid=%b id=%0d expected 1 %0d", rsp_valid, rsp_id, exp_id);
        end
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 70000 && m_cnt != 16'hFFFF; n++) begin
            @(posedge clk);
            #1;
            req_a[m_last*32 +: 32] = $urandom;
            req_b[m_last*32 +: 32] = ($urandom_range(0, 3) == 0) ? req_a[m_last*32 +: 32] : $urandom;
        end
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preset: op_count=%h expected ffff", op_count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (op_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: op_count=%h expected 0000", op_count);
        end
    endtask

    task automatic test_reset_midop();
        req_valid = 4'b0110;
        rsp_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset: valid=%b op_count=%h expected 0 0", rsp_valid, op_count);
        end
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL after_reset_g1: req_ready=%b expected 0010", req_ready);
        end
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100 || rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL after_reset_g2: req_ready=%b rsp_id=%0d expected 0100 1", req_ready, rsp_id);
        end
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_id !== 2'd2 || op_count !== 16'd2) begin
            errors++;
            $display("FAIL after_reset_rsp: rsp_id=%0d op_count=%0d expected 2 2", rsp_id, op_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle: busy=%b valid=%b expected 0 0", busy, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
